// File: rtl/lane_load_pkg.sv
// lane_load_pkg: shared FSM state type and lane-index width helper for lane_load_arbiter
package lane_load_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} lane_load_state_t;
  function automatic int lane_idx_w(input int bits);
    return $clog2(bits);
  endfunction
endpackage

// File: rtl/lane_reg.sv
// lane_reg: one result lane bit; ports clk, reset (async), clr_i (sync clear), we_i, d_i, q_o
module lane_reg (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic we_i,
  input  logic d_i,
  output logic q_o
);
  logic q_d;
  assign q_d = clr_i ? 1'b0 : we_i ? d_i : q_o;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_o <= 1'b0;
    else q_o <= q_d;
endmodule

// File: rtl/lane_load_arbiter.sv
// lane_load_arbiter: round-robin loader of a BITS-lane result bank, one lane per clock.
// Ports: clk, reset (async high); req0/req1 + data0/data1 in; grant0/grant1, busy, done,
// owner, lane, result out. Define LANE_LOAD_ARBITER_ASSERT_EN to compile in properties.
module lane_load_arbiter
  import lane_load_pkg::*;
#(
  parameter int BITS = 4,
  localparam int LANE_IDX_W = lane_idx_w(BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [BITS-1:0]       data0,
  input  logic [BITS-1:0]       data1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  busy,
  output logic                  done,
  output logic                  owner,
  output logic [LANE_IDX_W-1:0] lane,
  output logic [BITS-1:0]       result
);
  lane_load_state_t      state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [BITS-1:0]       snap_q, snap_d;
  logic                  grant0_q, grant0_d, grant1_q, grant1_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  accept, win1, loading, last_lane;
  always_comb begin
    accept    = state_q == IDLE && (req0 || req1);
    // on a tie the requester not served last wins
    win1      = req1 && (!req0 || !last_q);
    loading   = state_q == LOAD;
    last_lane = lane_q == LANE_IDX_W'(BITS - 1);
    state_d   = accept ? LOAD : (loading && last_lane) ? DONE : state_q == DONE ? IDLE : state_q;
    lane_d    = accept ? '0 : (loading && !last_lane) ? lane_q + LANE_IDX_W'(1) : lane_q;
    last_d    = accept ? win1 : last_q;
    owner_d   = accept ? win1 : owner_q;
    snap_d    = accept ? (win1 ? data1 : data0) : snap_q;
    grant0_d  = accept && !win1;
    grant1_d  = accept && win1;
    busy_d    = accept || (busy_q && !(loading && last_lane));
    done_d    = loading && last_lane;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      lane_q   <= '0;
      snap_q   <= '0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      lane_q   <= lane_d;
      snap_q   <= snap_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  for (genvar i = 0; i < BITS; i++) begin : g_lane
    lane_reg u_lane_reg (
      .clk   (clk),
      .reset (reset),
      .clr_i (accept),
      .we_i  (loading && lane_q == LANE_IDX_W'(i)),
      .d_i   (snap_q[i]),
      .q_o   (result[i])
    );
  end
  assign grant0 = grant0_q;
  assign grant1 = grant1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign owner  = owner_q;
  assign lane   = lane_q;
`ifdef LANE_LOAD_ARBITER_ASSERT_EN
  a_grant_excl: assert property (@(posedge clk) disable iff (reset) !(grant0 && grant1));
  a_done_full:  assert property (@(posedge clk) disable iff (reset) done |-> result == snap_q);
  a_busy_load:  assert property (@(posedge clk) disable iff (reset) busy |-> state_q == LOAD);
  a_lane_range: assert property (@(posedge clk) disable iff (reset) int'(lane_q) < BITS);
  // grants are registered, so the state one edge earlier must have been IDLE
  a_grant_idle: assert property (@(posedge clk) disable iff (reset)
                                 (grant0 || grant1) |-> $past(state_q) == IDLE);
  a_fair_0to1:  assert property (@(posedge clk) disable iff (reset)
                                 grant0 ##1 (req0 && req1) [*BITS+1] |=> grant1);
  a_fair_1to0:  assert property (@(posedge clk) disable iff (reset)
                                 grant1 ##1 (req0 && req1) [*BITS+1] |=> grant0);
`else
`endif
endmodule

// File: tb/tb_lane_load_arbiter.sv
// tb_lane_load_arbiter: directed plus random stimulus against a transaction-age reference model
module tb_lane_load_arbiter;
  localparam int BITS = 4;
  localparam int LW = $clog2(BITS);
  logic clk = 1'b0, reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [BITS-1:0] data0 = '0, data1 = '0;
  logic grant0, grant1, busy, done, owner;
  logic [LW-1:0] lane;
  logic [BITS-1:0] result;
  int vectors = 0, miscompares = 0;
  // model: t = cycles since acceptance, -1 when idle
  int t = -1, lanem = 0;
  bit lastm = 1'b1, ownm = 1'b0;
  logic [BITS-1:0] snapm = '0, resm = '0;
  lane_load_arbiter #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .grant0(grant0), .grant1(grant1), .busy(busy), .done(done), .owner(owner),
    .lane(lane), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic model_reset();
    t = -1; lanem = 0; lastm = 1'b1; ownm = 1'b0; snapm = '0; resm = '0;
  endtask
  task automatic model_step();
    bit w;
    if (t < 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? !lastm : req1;
        snapm = w ? data1 : data0;
        lastm = w; ownm = w; t = 0; resm = '0;
      end
    end else begin
      t++;
      if (t <= BITS) resm = snapm & BITS'((1 << t) - 1);
      if (t == BITS + 1) t = -1;
    end
    if (t >= 0) lanem = (t < BITS - 1) ? t : BITS - 1;
  endtask
  task automatic compare();
    chk("grant0", 32'(grant0), 32'(t == 0 && !ownm));
    chk("grant1", 32'(grant1), 32'(t == 0 && ownm));
    chk("busy",   32'(busy),   32'(t >= 0 && t < BITS));
    chk("done",   32'(done),   32'(t == BITS));
    chk("owner",  32'(owner),  32'(ownm));
    chk("lane",   32'(lane),   32'(lanem));
    chk("result", 32'(result), 32'(resm));
  endtask
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask
  initial begin
    do_reset();
    cyc(2);
    req0 = 1'b1; data0 = 4'b1010;
    cyc();
    req0 = 1'b0; data0 = 4'b0000;
    cyc(BITS + 2);
    req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'hC;
    cyc(4 * (BITS + 2));
    req0 = 1'b0; req1 = 1'b0;
    cyc(BITS + 2);
    req1 = 1'b1; data1 = 4'b0110;
    cyc();
    req1 = 1'b0; data1 = 4'b1111;
    cyc(BITS + 2);
    req0 = 1'b1; data0 = 4'b1101;
    cyc();
    req0 = 1'b0;
    cyc(2);
    chk("lane_before_reset", 32'(lane), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset = 1'b0;
    cyc(2);
    req0 = 1'b1; data0 = 4'b0111;
    cyc();
    req0 = 1'b0;
    cyc(BITS + 2);
    req0 = 1'b1; data0 = 4'b1001;
    cyc();
    req0 = 1'b0; req1 = 1'b1; data1 = 4'b0101;
    cyc(2);
    req1 = 1'b0;
    cyc(BITS + 2);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) req1 = 1'($urandom);
      data0 = BITS'($urandom);
      data1 = BITS'($urandom);
      if ($urandom_range(0, 150) == 0) do_reset();
      else cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(BITS + 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
